// File: rtl/fp_addsub_pipe.sv
// Four-stage pipelined floating-point adder/subtractor with round-to-nearest-even.
// A single global stall freezes every stage while the result is held unaccepted.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = EXP_W + MAN_W + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [2:0]   flags
);

    localparam int NW  = MAN_W + 4;          // hidden + mantissa + guard/round/sticky
    localparam int SW  = MAN_W + 5;          // NW plus carry-out
    localparam int XW  = EXP_W + 2;          // two's-complement exponent with headroom
    localparam int LZW = $clog2(NW + 1);
    localparam logic [W-1:0]  C_QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-2:0]  C_INF     = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
    localparam logic [XW-1:0] C_EXP_MAX = {2'b00, {EXP_W{1'b1}}};

    logic w_adv;
    assign in_ready = !(out_valid && !out_ready);
    assign w_adv    = in_ready;

    // ---------------- stage 1: unpack, classify, swap ----------------
    logic [1:0][W-1:0]     w_opnd;
    logic [1:0][EXP_W-1:0] w_exp;
    logic [1:0][MAN_W-1:0] w_man;
    logic [1:0]            w_sgn, w_zero, w_inf, w_nan;

    assign w_opnd = {b, a};
    assign w_sgn  = {b[W-1] ^ op, a[W-1]};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign w_exp[gi]  = w_opnd[gi][W-2:MAN_W];
            assign w_man[gi]  = w_opnd[gi][MAN_W-1:0];
            assign w_zero[gi] = (w_exp[gi] == '0);
            assign w_inf[gi]  = (&w_exp[gi]) && (w_man[gi] == '0);
            assign w_nan[gi]  = (&w_exp[gi]) && (w_man[gi] != '0);
        end
    endgenerate

    logic         w_spec, w_spec_inv;
    logic [W-1:0] w_spec_word;

    // Zero operands include flushed denormals, so x + 0 is returned untouched here.
    always_comb begin
        w_spec      = 1'b1;
        w_spec_inv  = 1'b0;
        w_spec_word = '0;
        if ((|w_nan) || ((&w_inf) && (w_sgn[0] != w_sgn[1]))) begin
            w_spec_word = C_QNAN;
            w_spec_inv  = 1'b1;
        end else if (w_inf[0]) begin
            w_spec_word = {w_sgn[0], C_INF};
        end else if (w_inf[1]) begin
            w_spec_word = {w_sgn[1], C_INF};
        end else if (&w_zero) begin
            w_spec_word = {&w_sgn, {(W-1){1'b0}}};
        end else if (w_zero[0]) begin
            w_spec_word = {w_sgn[1], b[W-2:0]};
        end else if (w_zero[1]) begin
            w_spec_word = a;
        end else begin
            w_spec = 1'b0;
        end
    end

    logic w_a_big;
    assign w_a_big = ({w_exp[0], w_man[0]} >= {w_exp[1], w_man[1]});

    logic             r_s1_valid, r_s1_spec, r_s1_spec_inv, r_s1_sign, r_s1_sub;
    logic [W-1:0]     r_s1_spec_word;
    logic [EXP_W-1:0] r_s1_exp, r_s1_diff;
    logic [MAN_W-1:0] r_s1_man_big, r_s1_man_sml;

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s1_spec      <= w_spec;
            r_s1_spec_inv  <= w_spec_inv;
            r_s1_spec_word <= w_spec_word;
            r_s1_sub       <= w_sgn[0] ^ w_sgn[1];
            r_s1_sign      <= w_a_big ? w_sgn[0] : w_sgn[1];
            r_s1_exp       <= w_a_big ? w_exp[0] : w_exp[1];
            r_s1_diff      <= w_a_big ? (w_exp[0] - w_exp[1]) : (w_exp[1] - w_exp[0]);
            r_s1_man_big   <= w_a_big ? w_man[0] : w_man[1];
            r_s1_man_sml   <= w_a_big ? w_man[1] : w_man[0];
        end
    end

    // ---------------- stage 2: align small operand ----------------
    logic [NW-1:0] w_sml_ext, w_sml_shf, w_lost_mask;
    logic          w_sticky;

    // Shifts past the word width yield zero, leaving the whole operand in sticky.
    assign w_sml_ext   = {1'b1, r_s1_man_sml, 3'b000};
    assign w_sml_shf   = w_sml_ext >> r_s1_diff;
    assign w_lost_mask = ~({NW{1'b1}} << r_s1_diff);
    assign w_sticky    = |(w_sml_ext & w_lost_mask);

    logic             r_s2_valid, r_s2_spec, r_s2_spec_inv, r_s2_sign, r_s2_sub;
    logic [W-1:0]     r_s2_spec_word;
    logic [EXP_W-1:0] r_s2_exp;
    logic [SW-1:0]    r_s2_big, r_s2_sml;

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s2_spec      <= r_s1_spec;
            r_s2_spec_inv  <= r_s1_spec_inv;
            r_s2_spec_word <= r_s1_spec_word;
            r_s2_sign      <= r_s1_sign;
            r_s2_sub       <= r_s1_sub;
            r_s2_exp       <= r_s1_exp;
            r_s2_big       <= {2'b01, r_s1_man_big, 3'b000};
            r_s2_sml       <= {1'b0, w_sml_shf[NW-1:1], w_sml_shf[0] | w_sticky};
        end
    end

    // ---------------- stage 3: add/subtract and leading-zero count ----------------
    logic [SW-1:0]  w_sum;
    logic [LZW-1:0] w_lzc;

    assign w_sum = r_s2_sub ? (r_s2_big - r_s2_sml) : (r_s2_big + r_s2_sml);

    always_comb begin
        w_lzc = LZW'(NW);
        for (int i = 0; i < NW; i++) begin
            if (w_sum[i]) w_lzc = LZW'(NW - 1 - i);
        end
    end

    logic             r_s3_valid, r_s3_spec, r_s3_spec_inv, r_s3_sign;
    logic [W-1:0]     r_s3_spec_word;
    logic [EXP_W-1:0] r_s3_exp;
    logic [SW-1:0]    r_s3_sum;
    logic [LZW-1:0]   r_s3_lzc;

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s3_spec      <= r_s2_spec;
            r_s3_spec_inv  <= r_s2_spec_inv;
            r_s3_spec_word <= r_s2_spec_word;
            r_s3_sign      <= r_s2_sign;
            r_s3_exp       <= r_s2_exp;
            r_s3_sum       <= w_sum;
            r_s3_lzc       <= w_lzc;
        end
    end

    // ---------------- stage 4a: normalise ----------------
    logic [NW-1:0] w_norm;
    logic [XW-1:0] w_nexp;

    always_comb begin
        w_norm = '0;
        w_nexp = '0;
        if (r_s3_sum[SW-1]) begin
            w_norm = {r_s3_sum[SW-1:2], |r_s3_sum[1:0]};
            w_nexp = XW'(r_s3_exp) + XW'(1);
        end else begin
            w_norm = r_s3_sum[NW-1:0] << r_s3_lzc;
            w_nexp = XW'(r_s3_exp) - XW'(r_s3_lzc);
        end
    end

    logic         r_s4_valid, r_s4_spec, r_s4_spec_inv, r_s4_sign, r_s4_zero;
    logic [W-1:0] r_s4_spec_word;
    logic [XW-1:0] r_s4_exp;
    logic [NW-1:0] r_s4_norm;

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s4_spec      <= r_s3_spec;
            r_s4_spec_inv  <= r_s3_spec_inv;
            r_s4_spec_word <= r_s3_spec_word;
            r_s4_sign      <= r_s3_sign;
            r_s4_zero      <= (r_s3_sum == '0);
            r_s4_exp       <= w_nexp;
            r_s4_norm      <= w_norm;
        end
    end

    // ---------------- stage 4b: round, range check, pack ----------------
    logic             w_rnd_inc;
    logic [MAN_W+1:0] w_mant_rnd;
    logic [MAN_W-1:0] w_man_field;
    logic [XW-1:0]    w_rexp;
    logic [W-1:0]     w_res;
    logic [2:0]       w_flg;

    assign w_rnd_inc   = r_s4_norm[2] & (r_s4_norm[1] | r_s4_norm[0] | r_s4_norm[3]);
    assign w_mant_rnd  = {1'b0, r_s4_norm[NW-1:3]} + (MAN_W+2)'(w_rnd_inc);
    assign w_rexp      = r_s4_exp + XW'(w_mant_rnd[MAN_W+1]);
    assign w_man_field = w_mant_rnd[MAN_W+1] ? w_mant_rnd[MAN_W:1] : w_mant_rnd[MAN_W-1:0];

    always_comb begin
        w_res = '0;
        w_flg = 3'b000;
        if (r_s4_spec) begin
            w_res = r_s4_spec_word;
            w_flg = {r_s4_spec_inv, 2'b00};
        end else if (r_s4_zero) begin
            w_res = '0;
        end else if (r_s4_exp[XW-1] || (r_s4_exp == '0)) begin
            w_res = {r_s4_sign, {(W-1){1'b0}}};
            w_flg = 3'b001;
        end else if (w_rexp >= C_EXP_MAX) begin
            w_res = {r_s4_sign, C_INF};
            w_flg = 3'b010;
        end else begin
            w_res = {r_s4_sign, w_rexp[EXP_W-1:0], w_man_field};
        end
    end

    logic         r_out_valid;
    logic [W-1:0] r_result;
    logic [2:0]   r_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s3_valid  <= 1'b0;
            r_s4_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
        end else if (w_adv) begin
            r_s1_valid  <= in_valid;
            r_s2_valid  <= r_s1_valid;
            r_s3_valid  <= r_s2_valid;
            r_s4_valid  <= r_s3_valid;
            r_out_valid <= r_s4_valid;
            r_result    <= w_res;
            r_flags     <= w_flg;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe (binary32): latency, rounding, specials, stall and reset.
module tb_fp_addsub_pipe;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 32;
    localparam logic [31:0] ONE = 32'h3F80_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         op = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] result;
    logic [2:0]   flags;

    int checks = 0;
    int failures = 0;

    logic [31:0] stream_a   [8] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                                    32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
    logic [31:0] stream_exp [8] = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000,
                                    32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000, 32'h4110_0000};

    always #5 clk = ~clk;

    fp_addsub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, got, exp);
    endtask

    // One isolated operation: result must appear exactly at the 4th edge after acceptance.
    task automatic single(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic top, input logic [31:0] er, input logic [2:0] ef);
        a = ta; b = tb_v; op = top; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int e = 1; e < 4; e++) begin
            @(posedge clk); #1;
            chk({tag, "_early"}, 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_res"}, result, er);
        chk({tag, "_flags"}, 32'(flags), 32'(ef));
        @(posedge clk); #1;
    endtask

    initial begin
        int idx;
        int got;
        int extra;

        // Reset state
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Basic arithmetic, signed zeros, rounding ties, range and specials
        single("one_plus_one", ONE, ONE, 1'b0, 32'h4000_0000, 3'b000);
        single("three_minus3", 32'h4040_0000, 32'h4040_0000, 1'b1, 32'h0000_0000, 3'b000);
        single("negz_minus_z", 32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, 3'b000);
        single("tie_even", ONE, 32'h3380_0000, 1'b0, 32'h3F80_0000, 3'b000);
        single("half_ulp_lsb", ONE, 32'h3400_0000, 1'b0, 32'h3F80_0001, 3'b000);
        single("overflow", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 3'b010);
        single("inf_minus_inf", 32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 3'b100);
        single("one_minus_half", ONE, 32'h3F00_0000, 1'b1, 32'h3F00_0000, 3'b000);
        single("mixed_sign", 32'hC000_0000, ONE, 1'b0, 32'hBF80_0000, 3'b000);
        single("carry_add", 32'h3FC0_0000, 32'h4020_0000, 1'b0, 32'h4080_0000, 3'b000);
        single("nan_in", 32'h7F80_0001, ONE, 1'b0, 32'h7FC0_0000, 3'b100);
        single("inf_plus_fin", 32'h7F80_0000, ONE, 1'b0, 32'h7F80_0000, 3'b000);
        single("x_plus_zero", 32'h4049_0FDB, 32'h0000_0000, 1'b0, 32'h4049_0FDB, 3'b000);
        single("denorm_flush", 32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0000_0000, 3'b000);
        single("underflow", 32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000, 3'b001);

        // Back-to-back stream with out_ready dropped for cycles 3..6
        idx = 0;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            if (idx < 8) begin
                in_valid = 1'b1; a = stream_a[idx]; b = ONE; op = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = !(cyc >= 3 && cyc <= 6);
            @(negedge clk);
            if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                chk($sformatf("stream_res%0d", got), result, stream_exp[got]);
                chk($sformatf("stream_flg%0d", got), 32'(flags), 32'd0);
                got++;
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", 32'(got), 32'd8);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("stream_no_dup", 32'(extra), 32'd0);
        @(posedge clk); #1;

        // Reset while results are in flight
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; a = stream_a[k]; b = ONE; op = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_result", result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk("no_stale_after_rst", 32'(extra), 32'd0);
        @(posedge clk); #1;
        single("post_rst", 32'h4040_0000, ONE, 1'b0, 32'h4080_0000, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
